ws2812_write_arbiter: RTL and testbench
=======================================

// Module: ws2812_write_arbiter
// PURPOSE
//  Shares the ws2812 LED register-file write port (rgb_data/led_num/write) between two requesters:
//  a host single-LED write channel and a range-fill engine.
//  Round-robin arbitration, a global brightness scale stage, and range checking of LED indices.
//  Sits between the register/host logic and the ws2812 serialiser; its outputs drive that core directly.
// PARAMETERS
//  NUM_LEDS  8  number of LEDs in the chain; valid indices 0..NUM_LEDS-1 (max 256)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  host_valid   in   1   host write request
//  host_ready   out  1   host request granted this cycle (combinational)
//  host_led     in   8   host target LED index
//  host_rgb     in   24  host colour, GRB order as sent on the wire
//  fill_start   in   1   one-cycle pulse: start a range fill
//  fill_first   in   8   first LED index of the fill (inclusive)
//  fill_last    in   8   last LED index of the fill (inclusive)
//  fill_rgb     in   24  fill colour
//  fill_busy    out  1   fill in progress
//  brightness   in   8   global scale; 255 = unscaled
//  ws_rgb_data  out  24  to ws2812 rgb_data
//  ws_led_num   out  8   to ws2812 led_num
//  ws_write     out  1   to ws2812 write, one cycle per LED update
//  err_range    out  1   one-cycle pulse on a rejected index or range
// BEHAVIOUR
//  Interface: one clock (clk); reset rst_n is asynchronous, active-low.
//  Reset values:
//  - ws_write=0, ws_rgb_data=0, ws_led_num=0, fill_busy=0, err_range=0.
//  - host_ready=0 while rst_n=0.
//  - Reset mid-fill drops the fill. Pipeline contents are discarded and no ws_write is issued.
//  FSM: IDLE, FILL.
//  - IDLE -> FILL on fill_start with fill_first<=fill_last<NUM_LEDS.
//    Latch first/last/rgb, set ptr=first, fill_busy=1 on the next cycle.
//  - If the range is invalid: err_range pulses 1 cycle later and the FSM stays in IDLE.
//  - fill_start while in FILL is ignored (no error, no relatch).
//  - FILL -> IDLE in the cycle the grant for ptr==last is issued; fill_busy drops on the next cycle.
//  Arbitration (stage 0), one grant per cycle:
//  - Only host pending: host_ready=host_valid.
//  - Only fill pending: fill granted.
//  - Both pending: alternate using a last_grant flag, which resets to "fill" so host wins first.
//  - A host transfer occurs on host_valid && host_ready.
//  - A fill grant emits ptr and then ptr<=ptr+1. ptr never wraps because last<NUM_LEDS.
//  - Host index >= NUM_LEDS: still accepted (host_ready=1), dropped, no ws_write.
//    err_range pulses in the stage-1 cycle.
//  Scale (stage 1):
//  - brightness is sampled at grant.
//  - Each 8-bit channel c -> ((c*(brightness+1))>>8), using a 17-bit product and bits [15:8].
//  - brightness=255 gives c unchanged; brightness=0 gives 0.
//  Output (stage 2): registered ws_rgb_data/ws_led_num; ws_write=1 for exactly one cycle.
//  Latency: a grant in cycle N gives ws_write in cycle N+2. Throughput is 1 write/cycle sustained.
//  ws_rgb_data/ws_led_num hold their last value while ws_write=0.
//  fill_first==fill_last is valid and produces exactly one write.
//  err_range: if a range error and a host index error coincide, a single pulse is emitted.
// TESTING
//  1. Reset then host write led=3 rgb=0x102030, brightness=255 -> ws_write 2 cycles later,
//     led_num=3, rgb=0x102030.
//  2. brightness=127, host rgb=0xFF8001 -> ws_rgb_data=0x7F4000.
//  3. fill first=2 last=5 rgb=0xAABBCC, no host traffic -> 4 consecutive ws_write, led 2,3,4,5;
//     fill_busy high 4 cycles.
//  4. fill 0..3 with host_valid held (led=7) -> interleaved led order 7,0,7,1,7,2,7,3
//     (host wins first grant).
//  5. host led=NUM_LEDS; fill first=5 last=2; fill last=NUM_LEDS ->
//     err_range pulses, no ws_write, FSM stays IDLE.
//  6. Assert rst_n low in the middle of fill 0..7 -> outputs reset immediately; after release no
//     further ws_write; fill_busy=0.

Source files
------------

// File: rtl/ws2812_write_arbiter_if.sv
// Purpose : bundles the host, fill, brightness and ws2812-side signals of the write arbiter.
// Latency : none (wiring only).
// Backpressure: host_ready is the only stall signal; fill requests are paced internally.
//
// Signals:
//   host_valid/host_ready/host_led/host_rgb  host single-LED write channel
//   fill_start/fill_first/fill_last/fill_rgb  range-fill request (one-cycle start pulse)
//   fill_busy                                 fill in progress
//   brightness                                global scale, 255 = unscaled
//   ws_rgb_data/ws_led_num/ws_write           drive the ws2812 core's write port
//   err_range                                 one-cycle pulse on a rejected index or range
//   modport master: requester/consumer side; modport slave: the arbiter.
interface ws2812_write_arbiter_if;
  logic        host_valid;
  logic        host_ready;
  logic [7:0]  host_led;
  logic [23:0] host_rgb;
  logic        fill_start;
  logic [7:0]  fill_first;
  logic [7:0]  fill_last;
  logic [23:0] fill_rgb;
  logic        fill_busy;
  logic [7:0]  brightness;
  logic [23:0] ws_rgb_data;
  logic [7:0]  ws_led_num;
  logic        ws_write;
  logic        err_range;

  modport master (
    output host_valid, host_led, host_rgb,
    output fill_start, fill_first, fill_last, fill_rgb,
    output brightness,
    input  host_ready, fill_busy,
    input  ws_rgb_data, ws_led_num, ws_write, err_range
  );

  modport slave (
    input  host_valid, host_led, host_rgb,
    input  fill_start, fill_first, fill_last, fill_rgb,
    input  brightness,
    output host_ready, fill_busy,
    output ws_rgb_data, ws_led_num, ws_write, err_range
  );
endinterface

// File: rtl/ws2812_write_arbiter.sv
// Purpose : round-robin share of the ws2812 write port between host writes and a range-fill engine, with brightness scaling.
// Latency : grant in cycle N -> ws_write in cycle N+2; sustains one write per cycle.
// Backpressure: host stalls via combinational host_ready when the fill wins; the ws2812 side never stalls.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    ws2812_write_arbiter_if.slave (host channel, fill request, brightness, ws2812 write port, err_range)
// Parameter NUM_LEDS: chain length, valid indices 0..NUM_LEDS-1 (at most 256).
module ws2812_write_arbiter #(
  parameter int NUM_LEDS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ws2812_write_arbiter_if.slave     bus
);

  // 9 bits so that NUM_LEDS=256 is representable and every 8-bit index compares correctly.
  localparam logic [8:0] NUM_LEDS_W = 9'(NUM_LEDS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  // Stage-1 payload: one granted write waiting to be scaled.
  typedef struct packed {
    logic        vld;
    logic [7:0]  led;
    logic [23:0] rgb;
    logic [7:0]  bright;
  } s1_t;

  // Fill engine state
  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_ptr;
  logic [7:0]  w_ptr_nxt;
  logic [7:0]  r_last;
  logic [7:0]  w_last_nxt;
  logic [23:0] r_fill_rgb;
  logic [23:0] w_fill_rgb_nxt;

  // Arbitration
  logic        r_last_grant_host;  // 1: host had the most recent grant
  logic        w_fill_pend;
  logic        w_host_rdy;
  logic        w_host_gnt;
  logic        w_fill_gnt;
  logic        w_range_ok;
  logic        w_range_err;
  logic        w_host_bad;

  // Pipeline
  s1_t         r_s1;
  s1_t         w_s1_nxt;
  logic [23:0] w_s1_scaled;
  logic [23:0] r_ws_rgb;
  logic [7:0]  r_ws_led;
  logic        r_ws_write;
  logic        r_err;

  // c * (b + 1) >> 8: b=255 returns c exactly, b=0 returns 0.
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] p;
    p = {9'd0, c} * {8'd0, ({1'b0, b} + 9'd1)};
    return 8'(p >> 8);
  endfunction

  // ---------------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------------
  assign w_fill_pend = (r_state == ST_FILL);

  assign w_range_ok  = (bus.fill_first <= bus.fill_last) &&
                       ({1'b0, bus.fill_last} < NUM_LEDS_W);

  // Start requests during a fill are ignored outright, so they can never raise an error.
  assign w_range_err = (r_state == ST_IDLE) && bus.fill_start && !w_range_ok;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration: when both sides want the port, the side that did
  // not win last time goes next. Reset value of r_last_grant_host (0) means the
  // host wins the first contested cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_host_rdy = 1'b0;
    if (rst_n && bus.host_valid) begin
      w_host_rdy = !w_fill_pend || !r_last_grant_host;
    end
  end

  assign w_host_gnt = bus.host_valid && w_host_rdy;
  assign w_fill_gnt = w_fill_pend && !w_host_gnt;

  // Out-of-range host writes are consumed but never reach the ws2812 core.
  assign w_host_bad = w_host_gnt && ({1'b0, bus.host_led} >= NUM_LEDS_W);

  // ---------------------------------------------------------------------------
  // Fill FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 8'd0;
      r_last     <= 8'd0;
      r_fill_rgb <= 24'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_last     <= w_last_nxt;
      r_fill_rgb <= w_fill_rgb_nxt;
    end
  end

  // Fill FSM: next state and latched parameters
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_last_nxt     = r_last;
    w_fill_rgb_nxt = r_fill_rgb;
    case (r_state)
      ST_IDLE: begin
        if (bus.fill_start && w_range_ok) begin
          w_state_nxt    = ST_FILL;
          w_ptr_nxt      = bus.fill_first;
          w_last_nxt     = bus.fill_last;
          w_fill_rgb_nxt = bus.fill_rgb;
        end
      end
      ST_FILL: begin
        if (w_fill_gnt) begin
          // last < NUM_LEDS, so ptr only passes last on the final grant, after which it is unused.
          w_ptr_nxt = r_ptr + 8'd1;
          if (r_ptr == r_last) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 0 -> stage 1: capture the granted write and the brightness in force
  // at grant time.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_s1_nxt        = '0;
    w_s1_nxt.bright = bus.brightness;
    if (w_fill_gnt) begin
      w_s1_nxt.vld = 1'b1;
      w_s1_nxt.led = r_ptr;
      w_s1_nxt.rgb = r_fill_rgb;
    end else if (w_host_gnt) begin
      w_s1_nxt.vld = !w_host_bad;
      w_s1_nxt.led = bus.host_led;
      w_s1_nxt.rgb = bus.host_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1              <= '0;
      r_last_grant_host <= 1'b0;
      r_err             <= 1'b0;
    end else begin
      r_s1  <= w_s1_nxt;
      // A range error and a host index error in the same cycle share one pulse.
      r_err <= w_range_err || w_host_bad;
      if (w_host_gnt) begin
        r_last_grant_host <= 1'b1;
      end else if (w_fill_gnt) begin
        r_last_grant_host <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 -> stage 2: per-channel brightness scale, then register the write.
  // ---------------------------------------------------------------------------
  assign w_s1_scaled = {scale_ch(r_s1.rgb[23:16], r_s1.bright),
                        scale_ch(r_s1.rgb[15:8],  r_s1.bright),
                        scale_ch(r_s1.rgb[7:0],   r_s1.bright)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ws_rgb   <= 24'd0;
      r_ws_led   <= 8'd0;
      r_ws_write <= 1'b0;
    end else begin
      r_ws_write <= r_s1.vld;
      // Data/index hold their last value between writes.
      if (r_s1.vld) begin
        r_ws_rgb <= w_s1_scaled;
        r_ws_led <= r_s1.led;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.host_ready  = w_host_rdy;
  assign bus.fill_busy   = (r_state == ST_FILL);
  assign bus.ws_rgb_data = r_ws_rgb;
  assign bus.ws_led_num  = r_ws_led;
  assign bus.ws_write    = r_ws_write;
  assign bus.err_range   = r_err;

endmodule

// File: tb/tb_ws2812_write_arbiter.sv
// Purpose : self-checking bench for ws2812_write_arbiter with a write scoreboard.
// Latency : checks grant-to-write distance of two cycles.
// Backpressure: exercises host stalls while a fill is running.
module tb_ws2812_write_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ws2812_write_arbiter_if bus();

  ws2812_write_arbiter #(.NUM_LEDS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Scoreboard entries: {led[7:0], rgb[23:0]}
  logic [31:0] sb[$];
  logic [31:0] exp_wr;
  bit          mon_en = 1'b1;
  int          n_writes = 0;
  int          first_wr_cyc = 0;
  int          last_wr_cyc = 0;
  int          busy_cnt = 0;
  int          err_cnt = 0;
  int          err_cyc = 0;

  always @(posedge clk) cyc++;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.fill_busy === 1'b1) busy_cnt++;
    if (bus.err_range === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.ws_write === 1'b1) begin
      n_writes++;
      if (n_writes == 1) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      if (mon_en) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got led=%0d rgb=%06h, scoreboard empty",
                   bus.ws_led_num, bus.ws_rgb_data);
        end else begin
          exp_wr = sb.pop_front();
          if ({bus.ws_led_num, bus.ws_rgb_data} !== exp_wr) begin
            errors++;
            $display("FAIL write_data: got led=%0d rgb=%06h, expected led=%0d rgb=%06h",
                     bus.ws_led_num, bus.ws_rgb_data, exp_wr[31:24], exp_wr[23:0]);
          end
        end
      end
    end
  end

  // Waits (bounded) for the scoreboard to empty, then a few more cycles to catch stray writes.
  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.host_valid = 1'b0;
    bus.host_led   = 8'd0;
    bus.host_rgb   = 24'd0;
    bus.fill_start = 1'b0;
    bus.fill_first = 8'd0;
    bus.fill_last  = 8'd0;
    bus.fill_rgb   = 24'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.brightness = 8'd255;
    bus.host_valid = 1'b1;   // host_ready must still be 0 while in reset
    bus.host_led   = 8'd1;
    #12;
    checks++; if (bus.ws_write !== 1'b0)     begin errors++; $display("FAIL rst_ws_write: got %b, expected 0", bus.ws_write); end
    checks++; if (bus.ws_rgb_data !== 24'd0) begin errors++; $display("FAIL rst_rgb: got %06h, expected 0", bus.ws_rgb_data); end
    checks++; if (bus.ws_led_num !== 8'd0)   begin errors++; $display("FAIL rst_led: got %0d, expected 0", bus.ws_led_num); end
    checks++; if (bus.fill_busy !== 1'b0)    begin errors++; $display("FAIL rst_fill_busy: got %b, expected 0", bus.fill_busy); end
    checks++; if (bus.err_range !== 1'b0)    begin errors++; $display("FAIL rst_err_range: got %b, expected 0", bus.err_range); end
    checks++; if (bus.host_ready !== 1'b0)   begin errors++; $display("FAIL rst_host_ready: got %b, expected 0", bus.host_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (n_writes != 0) begin errors++; $display("FAIL rst_no_write: got %0d writes, expected 0", n_writes); end
  endtask

  task automatic test_host_write();
    int g;
    bus.brightness = 8'd255;
    @(posedge clk); #1;
    n_writes = 0;
    bus.host_valid = 1'b1;
    bus.host_led   = 8'd3;
    bus.host_rgb   = 24'h102030;
    sb.push_back({8'd3, 24'h102030});
    g = cyc;
    @(negedge clk);
    checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL host_ready: got %b, expected 1", bus.host_ready); end
    @(posedge clk); #1;
    bus.host_valid = 1'b0;
    wait_drain(20);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL host_drain: %0d writes missing, expected 0", sb.size()); end
    checks++; if (last_wr_cyc - g != 2) begin errors++; $display("FAIL host_latency: got %0d cycles, expected 2", last_wr_cyc - g); end
    checks++; if (n_writes != 1) begin errors++; $display("FAIL host_count: got %0d writes, expected 1", n_writes); end
  endtask

  task automatic test_scale();
    n_writes = 0;
    @(posedge clk); #1;
    bus.brightness = 8'd127;
    bus.host_valid = 1'b1;
    bus.host_led   = 8'd1;
    bus.host_rgb   = 24'hFF8001;
    sb.push_back({8'd1, 24'h7F4000});
    @(posedge clk); #1;
    // Brightness is captured at grant, so changing it now must not affect the write above.
    bus.brightness = 8'd0;
    bus.host_led   = 8'd2;
    bus.host_rgb   = 24'hFFFFFF;
    sb.push_back({8'd2, 24'h000000});
    @(posedge clk); #1;
    bus.host_valid = 1'b0;
    wait_drain(20);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scale_drain: %0d writes missing, expected 0", sb.size()); end
    checks++; if (n_writes != 2) begin errors++; $display("FAIL scale_count: got %0d writes, expected 2", n_writes); end
    checks++; if (bus.ws_rgb_data !== 24'h000000) begin errors++; $display("FAIL scale_hold: got %06h, expected 000000", bus.ws_rgb_data); end
  endtask

  task automatic test_fill();
    bus.brightness = 8'd200;
    @(posedge clk); #1;
    n_writes = 0;
    busy_cnt = 0;
    bus.fill_start = 1'b1;
    bus.fill_first = 8'd2;
    bus.fill_last  = 8'd5;
    bus.fill_rgb   = 24'hAABBCC;
    for (int i = 2; i <= 5; i++) sb.push_back({8'(i), 24'h8592A0});
    @(posedge clk); #1;
    bus.fill_start = 1'b0;
    wait_drain(30);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL fill_drain: %0d writes missing, expected 0", sb.size()); end
    checks++; if (n_writes != 4) begin errors++; $display("FAIL fill_count: got %0d writes, expected 4", n_writes); end
    checks++; if (last_wr_cyc - first_wr_cyc != 3) begin errors++; $display("FAIL fill_back_to_back: span %0d cycles, expected 3", last_wr_cyc - first_wr_cyc); end
    checks++; if (busy_cnt != 4) begin errors++; $display("FAIL fill_busy_cycles: got %0d, expected 4", busy_cnt); end
  endtask

  task automatic test_fill_single();
    bus.brightness = 8'd255;
    @(posedge clk); #1;
    n_writes = 0;
    busy_cnt = 0;
    bus.fill_start = 1'b1;
    bus.fill_first = 8'd6;
    bus.fill_last  = 8'd6;
    bus.fill_rgb   = 24'h123456;
    sb.push_back({8'd6, 24'h123456});
    @(posedge clk); #1;
    bus.fill_start = 1'b0;
    wait_drain(20);
    checks++; if (n_writes != 1) begin errors++; $display("FAIL single_count: got %0d writes, expected 1", n_writes); end
    checks++; if (busy_cnt != 1) begin errors++; $display("FAIL single_busy: got %0d cycles, expected 1", busy_cnt); end
  endtask

  task automatic test_interleave();
    int ht;
    bus.brightness = 8'd255;
    for (int i = 0; i < 4; i++) begin
      sb.push_back({8'd7, 24'h010203});
      sb.push_back({8'(i), 24'hAABBCC});
    end
    @(posedge clk); #1;
    n_writes = 0;
    ht = 0;
    bus.host_valid = 1'b1;
    bus.host_led   = 8'd7;
    bus.host_rgb   = 24'h010203;
    bus.fill_start = 1'b1;
    bus.fill_first = 8'd0;
    bus.fill_last  = 8'd3;
    bus.fill_rgb   = 24'hAABBCC;
    for (int i = 0; i < 20 && ht < 4; i++) begin
      @(negedge clk);
      if (bus.host_valid && bus.host_ready === 1'b1) ht++;
      @(posedge clk); #1;
      bus.fill_start = 1'b0;
      if (ht == 4) bus.host_valid = 1'b0;
    end
    bus.host_valid = 1'b0;
    wait_drain(30);
    checks++; if (ht != 4) begin errors++; $display("FAIL ilv_host_xfers: got %0d, expected 4", ht); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL ilv_drain: %0d writes missing, expected 0", sb.size()); end
    checks++; if (n_writes != 8) begin errors++; $display("FAIL ilv_count: got %0d writes, expected 8", n_writes); end
  endtask

  task automatic test_errors();
    int d;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_writes = 0;
      busy_cnt = 0;
      err_cnt  = 0;
      d = cyc;
      case (k)
        0: begin bus.host_valid = 1'b1; bus.host_led = 8'd8; bus.host_rgb = 24'hFFFFFF; end
        1: begin bus.fill_start = 1'b1; bus.fill_first = 8'd5; bus.fill_last = 8'd2; end
        2: begin bus.fill_start = 1'b1; bus.fill_first = 8'd0; bus.fill_last = 8'd8; end
        default: begin
          bus.host_valid = 1'b1; bus.host_led = 8'd200;
          bus.fill_start = 1'b1; bus.fill_first = 8'd3; bus.fill_last = 8'd1;
        end
      endcase
      @(negedge clk);
      if (k == 0) begin
        checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL err_host_ready: got %b, expected 1", bus.host_ready); end
      end
      @(posedge clk); #1;
      idle_inputs();
      repeat (5) @(negedge clk);
      checks++; if (err_cnt != 1) begin errors++; $display("FAIL err_pulses_%0d: got %0d, expected 1", k, err_cnt); end
      checks++; if (err_cyc - d != 1) begin errors++; $display("FAIL err_timing_%0d: got %0d cycles, expected 1", k, err_cyc - d); end
      checks++; if (n_writes != 0) begin errors++; $display("FAIL err_no_write_%0d: got %0d writes, expected 0", k, n_writes); end
      checks++; if (busy_cnt != 0) begin errors++; $display("FAIL err_idle_%0d: fill_busy %0d cycles, expected 0", k, busy_cnt); end
    end
  endtask

  task automatic test_reset_mid_fill();
    mon_en = 1'b0;
    bus.brightness = 8'd255;
    @(posedge clk); #1;
    bus.fill_start = 1'b1;
    bus.fill_first = 8'd0;
    bus.fill_last  = 8'd7;
    bus.fill_rgb   = 24'h112233;
    @(posedge clk); #1;
    bus.fill_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.ws_write !== 1'b1) begin errors++; $display("FAIL mid_fill_active: ws_write %b, expected 1", bus.ws_write); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.ws_write !== 1'b0)     begin errors++; $display("FAIL mid_rst_write: got %b, expected 0", bus.ws_write); end
    checks++; if (bus.ws_rgb_data !== 24'd0) begin errors++; $display("FAIL mid_rst_rgb: got %06h, expected 0", bus.ws_rgb_data); end
    checks++; if (bus.ws_led_num !== 8'd0)   begin errors++; $display("FAIL mid_rst_led: got %0d, expected 0", bus.ws_led_num); end
    checks++; if (bus.fill_busy !== 1'b0)    begin errors++; $display("FAIL mid_rst_busy: got %b, expected 0", bus.fill_busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_writes = 0;
    busy_cnt = 0;
    sb.delete();
    repeat (15) @(negedge clk);
    checks++; if (n_writes != 0) begin errors++; $display("FAIL post_rst_writes: got %0d, expected 0", n_writes); end
    checks++; if (busy_cnt != 0) begin errors++; $display("FAIL post_rst_busy: got %0d cycles, expected 0", busy_cnt); end
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_scale();
    test_fill();
    test_fill_single();
    test_interleave();
    test_errors();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
